// File: rtl/demux_1x2_stream.sv
// Purpose : registered 1-to-2 stream demultiplexer; each word on A is steered by SEL
//           into one of two independent one-entry output slots with valid/ready.
// Latency : 1 cycle (word accepted at edge k is valid on Yn after edge k).
// Backpressure: A_READY depends only on the selected slot; a full slot whose consumer
//           is ready can be reloaded in the same cycle, so there is no bubble.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   A, SEL, A_VALID       input word, destination select (0 -> Y0, 1 -> Y1), valid
//   A_READY               input accepted this cycle (combinational)
//   Y0/Y0_VALID/Y0_READY  destination 0 data and handshake
//   Y1/Y1_VALID/Y1_READY  destination 1 data and handshake
//   CNT0, CNT1            wrapping counts of words delivered on each port
module demux_1x2_stream #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic             SEL,
    input  logic             A_VALID,
    output logic             A_READY,
    output logic [WIDTH-1:0] Y0,
    output logic             Y0_VALID,
    input  logic             Y0_READY,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_VALID,
    input  logic             Y1_READY,
    output logic [CNTW-1:0]  CNT0,
    output logic [CNTW-1:0]  CNT1
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e            state_q [2];
    slot_e            state_d [2];
    logic [WIDTH-1:0] dat_q   [2];
    logic [WIDTH-1:0] dat_d   [2];
    logic [CNTW-1:0]  cnt_q   [2];
    logic [CNTW-1:0]  cnt_d   [2];

    logic             out_rdy [2];
    logic             deliver [2];
    logic             load    [2];
    logic             sel_free;
    logic             accept;

    // Gather the per-port consumer readies so both slots share one code path.
    always_comb begin
        out_rdy[0] = Y0_READY;
        out_rdy[1] = Y1_READY;
    end

    // The selected slot can take a word if it is empty or is being drained this
    // cycle. The other slot never participates, so one stalled consumer cannot
    // block traffic to the other.
    always_comb begin
        sel_free = (state_q[SEL] == SLOT_EMPTY) || out_rdy[SEL];
        A_READY  = !RST && sel_free;
        accept   = A_VALID && A_READY;
        load[0]  = accept && !SEL;
        load[1]  = accept &&  SEL;
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            deliver[n] = (state_q[n] == SLOT_FULL) && out_rdy[n];
        end
    end

    // Next-state for each slot. A load always wins over a delivery, which is what
    // keeps Yn_VALID continuously high on a same-cycle drain and refill.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            dat_d[n]   = dat_q[n];
            cnt_d[n]   = cnt_q[n];

            case (state_q[n])
                SLOT_EMPTY: begin
                    if (load[n]) begin
                        state_d[n] = SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (deliver[n] && !load[n]) begin
                        state_d[n] = SLOT_EMPTY;
                    end
                end
                default: begin
                    state_d[n] = SLOT_EMPTY;
                end
            endcase

            // Data only changes on a load, so it is bit-stable while stalled and
            // keeps its last value once the slot drains.
            if (load[n]) begin
                dat_d[n] = A;
            end

            if (deliver[n]) begin
                cnt_d[n] = cnt_q[n] + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= SLOT_EMPTY;
                dat_q[n]   <= '0;
                cnt_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                dat_q[n]   <= dat_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    always_comb begin
        Y0       = dat_q[0];
        Y1       = dat_q[1];
        Y0_VALID = (state_q[0] == SLOT_FULL);
        Y1_VALID = (state_q[1] == SLOT_FULL);
        CNT0     = cnt_q[0];
        CNT1     = cnt_q[1];
    end

endmodule
